// File: rtl/img_readout_spi_chunker_if.sv
// Readout-word input and SPI byte output handshakes of the image readout chunker.
interface img_readout_spi_chunker_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        byte_req;
  logic [7:0]  spi_byte;
  logic        d_ready;

  modport master (
    output in_valid, in_data, byte_req,
    input  in_ready, spi_byte, d_ready
  );

  modport slave (
    input  in_valid, in_data, byte_req,
    output in_ready, spi_byte, d_ready
  );
endinterface

// File: rtl/img_readout_spi_chunker.sv
// Buffers 16-bit readout words into chunks and drains each chunk to the SPI shifter
// one byte at a time, low byte first, while tracking the total image length.
module img_readout_spi_chunker #(
  parameter int unsigned CHUNK_WORDS = 256,
  parameter int unsigned LEN_W       = 24
) (
  input  logic                       clk,
  input  logic                       rst_,
  input  logic                       start,
  input  logic                       abort,
  input  logic [LEN_W-1:0]           cfg_words,
  img_readout_spi_chunker_if.slave   bus,
  output logic                       done,
  output logic                       err
);
  localparam int unsigned AW = $clog2(CHUNK_WORDS);

  typedef enum logic [1:0] {StIdle, StFill, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [AW:0]       wr_idx_q, wr_idx_d;
  logic [AW+1:0]     rd_byte_q, rd_byte_d;
  logic [AW+1:0]     chunk_bytes_q, chunk_bytes_d;
  logic              d_ready_q, d_ready_d;
  logic              err_q, err_d;
  logic              wr_en;

  logic [15:0]       mem [CHUNK_WORDS];
  logic [15:0]       rdata_q;
  logic              hi_q;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    wr_idx_d      = wr_idx_q;
    rd_byte_d     = rd_byte_q;
    chunk_bytes_d = chunk_bytes_q;
    wr_en         = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (cfg_words == '0) begin
            state_d = StDone;
          end else begin
            remaining_d = cfg_words;
            wr_idx_d    = '0;
            state_d     = StFill;
          end
        end
      end
      StFill: begin
        if (bus.in_valid) begin
          wr_en       = 1'b1;
          wr_idx_d    = wr_idx_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (wr_idx_d == (AW+1)'(CHUNK_WORDS) || remaining_d == '0) begin
            chunk_bytes_d = {wr_idx_d, 1'b0};
            rd_byte_d     = '0;
            state_d       = StDrain;
          end
        end
      end
      StDrain: begin
        if (bus.byte_req) begin
          rd_byte_d = rd_byte_q + 1'b1;
          if (rd_byte_q == chunk_bytes_q - 1'b1) begin
            if (remaining_q != '0) begin
              wr_idx_d = '0;
              state_d  = StFill;
            end else begin
              state_d  = StDone;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
    end

    // d_ready waits one DRAIN cycle so the registered RAM read holds byte 0 first
    d_ready_d = (state_q == StDrain) && (state_d == StDrain);
    err_d     = err_q | (bus.byte_req && (state_q != StDrain));
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q       <= StIdle;
      remaining_q   <= '0;
      wr_idx_q      <= '0;
      rd_byte_q     <= '0;
      chunk_bytes_q <= '0;
      d_ready_q     <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      wr_idx_q      <= wr_idx_d;
      rd_byte_q     <= rd_byte_d;
      chunk_bytes_q <= chunk_bytes_d;
      d_ready_q     <= d_ready_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx_q[AW-1:0]] <= bus.in_data;
    end
  end

  // Read port only advances in DRAIN, so spi_byte is frozen everywhere else
  always_ff @(posedge clk) begin
    if (!rst_) begin
      rdata_q <= '0;
      hi_q    <= 1'b0;
    end else if (state_q == StDrain) begin
      rdata_q <= mem[rd_byte_q[AW:1]];
      hi_q    <= rd_byte_q[0];
    end
  end

  assign bus.in_ready = (state_q == StFill);
  assign bus.d_ready  = d_ready_q;
  assign bus.spi_byte = hi_q ? rdata_q[15:8] : rdata_q[7:0];
  assign done         = (state_q == StDone);
  assign err          = err_q;
endmodule

// File: tb/tb_img_readout_spi_chunker.sv
// Randomized bench for img_readout_spi_chunker against a byte-stream / chunk-length model.
module tb_img_readout_spi_chunker;
  localparam int unsigned CW = 256;
  localparam int unsigned LW = 24;

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [LW-1:0] cfg_words = '0;
  logic          done;
  logic          err;

  img_readout_spi_chunker_if bus ();

  img_readout_spi_chunker #(
    .CHUNK_WORDS (CW),
    .LEN_W       (LW)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .start     (start),
    .abort     (abort),
    .cfg_words (cfg_words),
    .bus       (bus),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  logic [15:0] words[$];
  logic [7:0]  exp_bytes[$];
  int          exp_chunks[$];
  int          obs_chunks[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  // Drives one image from the words queue; compares bytes, chunk sizes and edge timing.
  task automatic run_image(input bit rnd, input int abort_after, input bit inject_err);
    int n, idx, sent, cool, cur, bad_ir, rem, c;
    int last_xfer, last_req;
    bit prev_dr, fin, injected, v;
    n = words.size();
    exp_bytes.delete();
    exp_chunks.delete();
    obs_chunks.delete();
    foreach (words[i]) begin
      exp_bytes.push_back(words[i][7:0]);
      exp_bytes.push_back(words[i][15:8]);
    end
    rem = n;
    while (rem > 0) begin
      c = (rem > int'(CW)) ? int'(CW) : rem;
      exp_chunks.push_back(2 * c);
      rem -= c;
    end
    idx = 0; sent = 0; cool = 0; cur = 0; bad_ir = 0;
    last_xfer = -100; last_req = -100;
    prev_dr = 0; fin = 0; injected = 0;

    start = 1'b1;
    cfg_words = LW'(n);
    bus.in_valid = 1'b0;
    bus.byte_req = 1'b0;
    tick();
    start = 1'b0;

    for (int k = 0; k < 20000; k++) begin
      if (bus.d_ready && !prev_dr) begin
        check("d_ready_latency", cyc - last_xfer, 2);
        cur = 0;
      end
      if (!bus.d_ready && prev_dr) begin
        check("d_ready_fall", cyc - last_req, 1);
        check("post_chunk_state", {31'b0, bus.in_ready | done}, 1);
        obs_chunks.push_back(cur);
      end
      if (bus.d_ready && bus.in_ready) bad_ir++;
      prev_dr = bus.d_ready;
      if (done) begin
        fin = 1;
        break;
      end

      bus.byte_req = 1'b0;
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (idx < n && v) begin
        bus.in_valid = 1'b1;
        bus.in_data  = words[idx];
        if (bus.in_ready) begin
          idx++;
          last_xfer = cyc;
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      if (inject_err && !injected && bus.in_ready && idx == 2) begin
        bus.byte_req = 1'b1;
        injected = 1;
      end

      if (cool > 0) begin
        cool--;
      end else if (bus.d_ready) begin
        if (abort_after >= 0 && sent == abort_after) begin
          abort = 1'b1;
          bus.in_valid = 1'b0;
          tick();
          abort = 1'b0;
          check("abort_d_ready", {31'b0, bus.d_ready}, 0);
          check("abort_in_ready", {31'b0, bus.in_ready}, 0);
          check("abort_done", {31'b0, done}, 0);
          return;
        end
        if (exp_bytes.size() == 0) begin
          check("extra_byte", 1, 0);
        end else begin
          check("spi_byte", {24'b0, bus.spi_byte}, {24'b0, exp_bytes.pop_front()});
        end
        bus.byte_req = 1'b1;
        sent++;
        cur++;
        last_req = cyc;
        cool = rnd ? int'($urandom_range(2, 9)) : 2;
      end
      tick();
    end

    bus.in_valid = 1'b0;
    bus.byte_req = 1'b0;
    if (!fin) check("timeout", 0, 1);
    check("words_sent", idx, n);
    check("bytes_left", exp_bytes.size(), 0);
    check("chunk_count", obs_chunks.size(), exp_chunks.size());
    if (obs_chunks.size() == exp_chunks.size()) begin
      foreach (exp_chunks[i]) check("chunk_len", obs_chunks[i], exp_chunks[i]);
    end
    check("in_ready_in_drain", bad_ir, 0);
    if (inject_err) check("err_sticky", {31'b0, err}, 1);
  endtask

  task automatic fill_incr(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'(i));
  endtask

  task automatic fill_rand(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.byte_req = 1'b0;
    repeat (3) tick();
    rst_ = 1'b1;
    tick();
    check("rst_in_ready", {31'b0, bus.in_ready}, 0);
    check("rst_d_ready", {31'b0, bus.d_ready}, 0);
    check("rst_spi_byte", {24'b0, bus.spi_byte}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);

    // Short single chunk with fixed words
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    words.push_back(16'h0001);
    words.push_back(16'hFF00);
    run_image(1'b0, -1, 1'b0);

    // Multi-chunk with remainder, full rate, then the same stream under backpressure
    fill_incr(600);
    run_image(1'b0, -1, 1'b0);
    fill_incr(600);
    run_image(1'b1, -1, 1'b0);

    // Abort mid-DRAIN, then a fresh short image
    fill_rand(600);
    run_image(1'b1, 100, 1'b0);
    fill_rand(4);
    run_image(1'b0, -1, 1'b0);

    // Zero-length image
    start = 1'b1;
    cfg_words = '0;
    tick();
    start = 1'b0;
    check("zero_done", {31'b0, done}, 1);
    check("zero_in_ready", {31'b0, bus.in_ready}, 0);
    check("zero_d_ready", {31'b0, bus.d_ready}, 0);
    bad = 0;
    repeat (4) begin
      tick();
      if (bus.in_ready || bus.d_ready) bad++;
    end
    check("zero_quiet", bad, 0);

    // Protocol error during FILL
    check("err_before", {31'b0, err}, 0);
    fill_rand(4);
    run_image(1'b1, -1, 1'b1);
    fill_rand(300);
    run_image(1'b1, -1, 1'b0);
    check("err_still_set", {31'b0, err}, 1);

    // Reset mid-FILL after 10 words
    start = 1'b1;
    cfg_words = LW'(40);
    tick();
    start = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus.in_ready) bad++;
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(i);
      tick();
    end
    check("midfill_in_ready", bad, 0);
    bus.in_valid = 1'b0;
    rst_ = 1'b0;
    tick();
    rst_ = 1'b1;
    check("rst2_in_ready", {31'b0, bus.in_ready}, 0);
    check("rst2_d_ready", {31'b0, bus.d_ready}, 0);
    check("rst2_spi_byte", {24'b0, bus.spi_byte}, 0);
    check("rst2_done", {31'b0, done}, 0);
    check("rst2_err", {31'b0, err}, 0);
    bad = 0;
    repeat (20) begin
      tick();
      if (bus.d_ready || bus.in_ready) bad++;
    end
    check("rst2_quiet", bad, 0);
    fill_rand(5);
    run_image(1'b1, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/img_readout_spi_chunker.md
# img_readout_spi_chunker

Sits directly downstream of the RAM image-readout FIFO and upstream of the STM SPI data port. It accepts 16-bit pixel words from the readout path and buffers them into chunks of up to CHUNK_WORDS words. For each complete chunk it raises the ready signal that drives ice_stm_spi_d_ready, then hands the chunk to the SPI byte shifter one byte at a time, low byte first. It also tracks the total image length and reports completion.

## Interface
Parameters:
- CHUNK_WORDS, 256, words per chunk; power of two, 2..512.
- LEN_W, 24, width of the image length in words.

Ports:
- clk  in  1  single clock for the block.
- rst_  in  1  reset; synchronous, active-low.
- start  in  1  one-cycle pulse; begin a readout of cfg_words words.
- abort  in  1  one-cycle pulse; abandon the readout and return to IDLE.
- cfg_words  in  LEN_W  image length in words; sampled only on an accepted start.
- in_valid  in  1  readout word valid.
- in_ready  out  1  block accepts the word.
- in_data  in  16  readout word.
- byte_req  in  1  one-cycle pulse from the SPI shifter; the current byte was consumed.
- spi_byte  out  8  current byte to shift.
- d_ready  out  1  a chunk is buffered and being drained; drives ice_stm_spi_d_ready.
- done  out  1  all cfg_words words have been drained.
- err  out  1  sticky; set when byte_req arrives outside DRAIN.

## Operation
- Buffer: CHUNK_WORDS x 16 single-port-write / single-port-read RAM with registered read (iCE40 BRAM).
- State IDLE:
  - in_ready=0, d_ready=0.
  - start with cfg_words=0 -> DONE.
  - start with cfg_words>0 -> latch remaining=cfg_words, set wr_idx=0, go to FILL.
- State FILL:
  - in_ready=1.
  - Each in_valid&in_ready transfer writes buf[wr_idx], increments wr_idx and decrements remaining.
  - The transfer that makes wr_idx=CHUNK_WORDS or remaining=0 ends the fill.
  - On that transfer: latch chunk_bytes=2*wr_idx (post-increment), set rd_byte=0, go to DRAIN.
  - in_ready drops in the cycle after that transfer.
- State DRAIN:
  - in_ready=0.
  - d_ready=1 once spi_byte holds byte 0; see Timing.
  - spi_byte = rd_byte[0] ? buf[rd_byte>>1][15:8] : buf[rd_byte>>1][7:0].
  - Each byte_req increments rd_byte.
  - The byte_req at rd_byte=chunk_bytes-1 deasserts d_ready on the next cycle. It then goes to FILL (wr_idx=0) if remaining>0, otherwise to DONE.
- State DONE:
  - done=1.
  - start is accepted exactly as in IDLE; done clears when start is accepted.
- abort (any state):
  - Next cycle: IDLE, in_ready=0, d_ready=0, done=0.
  - Buffer contents are discarded. err is not cleared.
- start outside IDLE/DONE: ignored.
- start and abort in the same cycle: abort wins.
- byte_req outside DRAIN: ignored for data, sets err. err clears only on reset.
- Arithmetic widths:
  - remaining is LEN_W bits and never underflows, because FILL exits at 0.
  - wr_idx is log2(CHUNK_WORDS)+1 bits.
  - rd_byte and chunk_bytes are log2(CHUNK_WORDS)+2 bits.
- Reset values: state=IDLE, in_ready=0, d_ready=0, spi_byte=0, done=0, err=0, all counters 0.

## Timing
- FILL: one word per cycle at full rate; no bubble between consecutive accepted words.
- Fill-to-drain latency:
  - Last write accepted at cycle t.
  - Byte 0 is read from RAM at t+1 and registered into spi_byte at t+2.
  - d_ready asserts at t+2.
- Byte advance: byte_req at cycle t -> spi_byte shows the next byte at t+2. The SPI side guarantees byte_req pulses at least 3 cycles apart.
- Last byte_req at t: d_ready=0 at t+1. The state is FILL (in_ready=1) or DONE (done=1) at t+1.
- Exactly one chunk is in flight at a time; no ping-pong buffering.
- spi_byte holds its value outside DRAIN. Its value there is meaningless but stable.

## Test plan
- Single short chunk: cfg_words=4, words 0x1234, 0xABCD, 0x0001, 0xFF00 at full rate.
  - d_ready rises 2 cycles after the 4th transfer.
  - Bytes read are 34 12 CD AB 01 00 00 FF.
  - done=1 one cycle after the 8th byte_req.
- Multi-chunk with remainder: cfg_words=600, CHUNK_WORDS=256, incrementing data 0..599.
  - Three d_ready pulses, of 512, 512 and 176 bytes.
  - Byte stream matches little-endian 0..599.
  - in_ready=0 throughout every DRAIN.
- Backpressure and gaps: in_valid toggled randomly, with byte_req spacing randomly 3..10 cycles.
  - Byte stream identical to the full-rate run; no word lost or duplicated.
- Abort mid-DRAIN:
  - abort after 100 bytes of chunk 1 -> d_ready=0 and IDLE next cycle.
  - A fresh start with cfg_words=4 then produces the correct 8 bytes.
- Zero length and protocol error:
  - start with cfg_words=0 -> done=1 the next cycle; in_ready and d_ready never assert.
  - byte_req during FILL -> err=1 and stays 1; the state and the byte stream are unaffected.
- Reset mid-FILL: rst_=0 for one cycle after 10 words.
  - All outputs return to their reset values the next cycle.
  - No d_ready until a new start.
